// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and scan-code constants, also used by the key-decoding stage.
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a stability filter: the output only follows the input
// after FILTER_LEN consecutive identical synchronised samples.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] stable_cnt;

    // Lines idle high, so the whole chain resets to 1 to avoid a spurious edge on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1     <= 1'b1;
            sync_2     <= 1'b1;
            filt       <= 1'b1;
            stable_cnt <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            if (sync_2 == filt) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(FILTER_LEN - 1)) begin
                filt       <= sync_2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 device-to-host frame receiver: checks start/odd parity/stop and keeps a two-byte
// history of good bytes as {previous, latest}.
//
//  state  | meaning
//  IDLE   | waiting for a start bit (data low on a clock falling edge)
//  DATA   | shifting in 8 data bits, LSB first
//  PARITY | capturing the odd-parity bit
//  STOP   | checking stop bit and parity, then updating keycode or flagging an error
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] keycode,
    output logic        keycode_valid,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic          clk_f;
    logic          data_f;
    logic          clk_q;
    logic          fall_stb;
    ps2_state_t    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    sr;
    logic          par;
    logic [TW-1:0] tmo_cnt;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (ps2_clk),
        .filt  (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (ps2_data),
        .filt  (data_f)
    );

    assign fall_stb = clk_q & ~clk_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_q         <= 1'b1;
            state         <= IDLE;
            bit_cnt       <= '0;
            sr            <= '0;
            par           <= 1'b0;
            tmo_cnt       <= '0;
            keycode       <= '0;
            keycode_valid <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            clk_q         <= clk_f;
            keycode_valid <= 1'b0;
            frame_err     <= 1'b0;

            if (state == IDLE || fall_stb) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != '1) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (fall_stb) begin
                case (state)
                    IDLE: begin
                        if (!data_f) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        sr      <= {data_f, sr[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par   <= data_f;
                        state <= STOP;
                    end
                    STOP: begin
                        if (data_f && (^{sr, par})) begin
                            keycode       <= {keycode[7:0], sr};
                            keycode_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                // Device stalled mid-frame: drop the partial byte.
                frame_err <= 1'b1;
                state     <= IDLE;
                bit_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench: a PS/2 device model drives frames, a scoreboard of expected keycodes is
// checked whenever keycode_valid pulses.
module tb_ps2_keycode_rx;
    import ps2_pkg::*;

    localparam int HALF = 20;
    localparam int TMO  = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] keycode;
    logic        keycode_valid;
    logic        frame_err;

    int          tests = 0;
    int          fails = 0;
    int          n_valid = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_kc = 16'h0000;

    ps2_keycode_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .keycode       (keycode),
        .keycode_valid (keycode_valid),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (keycode_valid || frame_err) begin
                tests++;
                assert (!(keycode_valid && frame_err)) else begin
                    fails++;
                    $error("FAIL excl kv=%0b fe=%0b required not both high", keycode_valid, frame_err);
                end
            end
            if (keycode_valid) begin
                n_valid++;
                tests++;
                assert (exp_q.size() > 0) else begin
                    fails++;
                    $error("FAIL sb_unexpected keycode=%h required no pulse", keycode);
                end
                if (exp_q.size() > 0) begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    tests++;
                    assert (keycode === e) else begin
                        fails++;
                        $error("FAIL sb_keycode observed=%h expected=%h", keycode, e);
                    end
                end
            end
            if (frame_err) n_err++;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        ps2_clk = 1'b1;
        cyc(HALF / 2);
        ps2_data = b;
        if (glitch) begin
            cyc(2);
            ps2_clk = 1'b0;
            cyc(3);
            ps2_clk = 1'b1;
            cyc(HALF / 2 - 5);
        end else begin
            cyc(HALF / 2);
        end
        ps2_clk = 1'b0;
        cyc(HALF);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit glitch);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(bits[i], glitch && (i > 0));
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b, input bit glitch);
        model_kc = {model_kc[7:0], b};
        exp_q.push_back(model_kc);
        send_frame(b, 1'b0, 11, glitch);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int e0;

        cyc(3);
        chk("rst_keycode", int'(keycode), 16'h0000);
        chk("rst_valid", int'(keycode_valid), 0);
        chk("rst_err", int'(frame_err), 0);
        rst_n = 1'b1;
        cyc(10);

        v0 = n_valid; e0 = n_err;
        send_good(8'h1C, 1'b0);
        cyc(20);
        chk("s1_keycode", int'(keycode), 16'h001C);
        chk("s1_valid_cnt", n_valid - v0, 1);
        chk("s1_err_cnt", n_err - e0, 0);

        v0 = n_valid; e0 = n_err;
        send_good(PS2_BREAK, 1'b0);
        send_good(8'h1C, 1'b0);
        cyc(20);
        chk("s2_keycode", int'(keycode), 16'hF01C);
        chk("s2_valid_cnt", n_valid - v0, 2);
        chk("s2_err_cnt", n_err - e0, 0);

        v0 = n_valid; e0 = n_err;
        send_frame(8'h23, 1'b1, 11, 1'b0);
        cyc(20);
        chk("s3_bad_err_cnt", n_err - e0, 1);
        chk("s3_bad_valid_cnt", n_valid - v0, 0);
        chk("s3_bad_keycode", int'(keycode), 16'hF01C);
        send_good(8'h23, 1'b0);
        cyc(20);
        chk("s3_good_keycode", int'(keycode), 16'h1C23);
        chk("s3_good_valid_cnt", n_valid - v0, 1);

        v0 = n_valid; e0 = n_err;
        send_frame(8'h5A, 1'b0, 5, 1'b0);
        cyc(TMO + 100);
        chk("s4_tmo_err_cnt", n_err - e0, 1);
        chk("s4_state", int'(dut.state), int'(IDLE));
        chk("s4_tmo_keycode", int'(keycode), 16'h1C23);
        send_good(8'h5A, 1'b0);
        cyc(20);
        chk("s4_keycode", int'(keycode), 16'h235A);
        chk("s4_valid_cnt", n_valid - v0, 1);

        v0 = n_valid; e0 = n_err;
        send_good(8'h1D, 1'b1);
        cyc(20);
        chk("s5_keycode", int'(keycode), 16'h5A1D);
        chk("s5_valid_cnt", n_valid - v0, 1);
        chk("s5_err_cnt", n_err - e0, 0);

        send_frame(8'h1C, 1'b0, 5, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("s6_rst_keycode", int'(keycode), 16'h0000);
        chk("s6_rst_valid", int'(keycode_valid), 0);
        model_kc = 16'h0000;
        exp_q.delete();
        cyc(5);
        rst_n = 1'b1;
        cyc(10);
        v0 = n_valid; e0 = n_err;
        send_good(8'h1C, 1'b0);
        cyc(20);
        chk("s6_keycode", int'(keycode), 16'h001C);
        chk("s6_valid_cnt", n_valid - v0, 1);
        chk("s6_err_cnt", n_err - e0, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
